// File: rtl/mips_mmio_pkg.sv
// Shared definitions for memory-mapped peripherals on the multicycle MIPS data bus:
// register offsets, STATUS bit positions and the UART transmit FSM encoding.
package mips_mmio_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_EMPTY     = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_PAR       = 4;
    localparam int STAT_COUNT_LSB = 8;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_txfifo.sv
// Synchronous FIFO for the UART transmitter: push while full is dropped, pop while
// empty is ignored. Pointers wrap naturally because DEPTH is a power of two.
module uart_txfifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Fullness is judged on the registered count, so a same-cycle pop never makes room.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a store-byte FIFO and combinational STATUS read.
// Optional even-parity bit compiled in with UART_TX_PARITY_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// TX_IDLE   | line high, waiting for a byte in the FIFO
// TX_START  | start bit (low) for one bit period
// TX_DATA   | data bits 0..7, LSB first, one bit period each
// TX_PARITY | even parity over the data byte (only with UART_TX_PARITY_EN)
// TX_STOP   | stop bit (high); chains straight into the next START if data waits
module uart_tx_mmio
    import mips_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] adr,
    input  logic [31:0] writedata,
    input  logic        memwrite,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        tx
);

    localparam int                CNTW     = $clog2(CLKS_PER_BIT);
    localparam int                FCW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNTW-1:0]   CNT_LAST = CNTW'(CLKS_PER_BIT - 1);

    tx_state_e         state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              ovf_q, ovf_d;

    logic [1:0]        reg_sel;
    logic              wr_en;
    logic              push;
    logic              pop;
    logic              bit_last;
    logic [7:0]        fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FCW-1:0]    fifo_count;
    logic [31:0]       status;
    logic              unused_ok;

    assign hit      = (adr[31:4] == BASE_ADDR[31:4]);
    assign reg_sel  = adr[3:2];
    assign wr_en    = hit & memwrite;
    assign push     = wr_en & (reg_sel == REG_TXDATA);
    assign unused_ok = ^{adr[1:0], writedata[31:8], writedata[7:4], writedata[2:0]};

    uart_txfifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_txfifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (writedata[7:0]),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // A dropped push sets overflow even if software clears it in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_en && (reg_sel == REG_STATUS) && writedata[STAT_OVF]) begin
            ovf_d = 1'b0;
        end
        if (push && fifo_full) begin
            ovf_d = 1'b1;
        end
    end

    assign bit_last = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_d    = 1'b1;

        case (state_q)
            TX_IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    bit_d   = '0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (bit_last) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (bit_last) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = TX_PARITY;
`else
                        state_d = TX_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY: begin
                if (bit_last) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = TX_STOP;
                end
            end
`endif
            TX_STOP: begin
                if (bit_last) begin
                    cnt_d = '0;
                    bit_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        state_d = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = TX_IDLE;
            end
        endcase

        // tx is registered from the next state so the line changes on the same edge as the FSM.
        case (state_d)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = shift_d[bit_d];
`ifdef UART_TX_PARITY_EN
            TX_PARITY: tx_d = even_parity(shift_d);
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign tx = tx_q;

    always_comb begin
        status                             = '0;
        status[STAT_BUSY]                  = (state_q != TX_IDLE);
        status[STAT_FULL]                  = fifo_full;
        status[STAT_EMPTY]                 = fifo_empty;
        status[STAT_OVF]                   = ovf_q;
`ifdef UART_TX_PARITY_EN
        status[STAT_PAR]                   = 1'b1;
`endif
        status[STAT_COUNT_LSB +: 8]        = 8'(fifo_count);
    end

    assign rdata = (hit && (reg_sel == REG_STATUS)) ? status : 32'h0;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio at CLKS_PER_BIT=4: a serial monitor decodes
// every frame on tx and compares it against bytes queued when the stores were issued.
module tb_uart_tx_mmio;

    localparam int          CPB  = 4;
    localparam logic [31:0] BASE = 32'hFFFF_FF00;
`ifdef UART_TX_PARITY_EN
    localparam int          NBITS = 11;
    localparam logic [31:0] PARB  = 32'h10;
`else
    localparam int          NBITS = 10;
    localparam logic [31:0] PARB  = 32'h0;
`endif
    localparam int          FRAME    = NBITS * CPB;
    localparam logic [31:0] EXP_IDLE = 32'h4 | PARB;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] adr;
    logic [31:0] writedata;
    logic        memwrite;
    logic        hit;
    logic [31:0] rdata;
    logic        tx;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic        mon_en = 1'b1;
    logic        mon_busy = 1'b0;
    logic [7:0]  sb[$];
    int          starts[$];
    logic        smp [NBITS*CPB];

    uart_tx_mmio #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .adr       (adr),
        .writedata (writedata),
        .memwrite  (memwrite),
        .hit       (hit),
        .rdata     (rdata),
        .tx        (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        adr       = a;
        writedata = d;
        memwrite  = 1'b1;
        @(posedge clk);
        #1;
        memwrite  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h);
        adr      = a;
        memwrite = 1'b0;
        #1;
        d = rdata;
        h = hit;
    endtask

    task automatic send(input logic [7:0] b);
        sb.push_back(b);
        wr(BASE, {24'h0, b});
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((sb.size() != 0 || mon_busy) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= budget) check("wait_idle_timeout", 32'(n), 32'(budget - 1));
    endtask

    // Serial monitor: once the line drops, capture one whole frame and decode it.
    initial begin : monitor
        int          unstable;
        logic [7:0]  data;
        logic [7:0]  exp;
        forever begin
            @(negedge clk);
            if (mon_en && !reset && tx === 1'b0) begin
                mon_busy = 1'b1;
                starts.push_back(cyc);
                smp[0] = tx;
                for (int i = 1; i < NBITS * CPB; i++) begin
                    @(negedge clk);
                    smp[i] = tx;
                end
                unstable = 0;
                for (int b = 0; b < NBITS; b++)
                    for (int c = 1; c < CPB; c++)
                        if (smp[b*CPB + c] !== smp[b*CPB]) unstable++;
                check("bit_stable", 32'(unstable), 32'h0);
                for (int i = 0; i < 8; i++) data[i] = smp[(1 + i) * CPB];
                check("stop_bit", {31'h0, smp[(NBITS-1)*CPB]}, 32'h1);
                if (sb.size() == 0) begin
                    check("unexpected_frame", {24'h0, data}, 32'hFFFF_FFFF);
                end else begin
                    exp = sb.pop_front();
                    check("frame_data", {24'h0, data}, {24'h0, exp});
`ifdef UART_TX_PARITY_EN
                    check("parity_bit", {31'h0, smp[9*CPB]}, {31'h0, ^exp});
`endif
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : main
        logic [31:0] d;
        logic        h;
        int          ntx;

        reset     = 1'b1;
        adr       = 32'h0;
        writedata = 32'h0;
        memwrite  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("tx_in_reset", {31'h0, tx}, 32'h1);
        reset = 1'b0;

        // Reset state and address decode
        rd(BASE + 32'h4, d, h);
        check("status_hit", {31'h0, h}, 32'h1);
        check("status_reset", d, EXP_IDLE);
        rd(32'h0000_0004, d, h);
        check("miss_hit", {31'h0, h}, 32'h0);
        check("miss_rdata", d, 32'h0);
        rd(BASE + 32'h7, d, h);
        check("status_lowbits_ignored", d, EXP_IDLE);
        rd(BASE, d, h);
        check("txdata_reads_zero", d, 32'h0);
        rd(BASE + 32'h8, d, h);
        check("reg2_reads_zero", d, 32'h0);

        // Single byte: pop timing, tx fall, busy duration
        send(8'hA5);
        rd(BASE + 32'h4, d, h);
        check("status_after_push", d, 32'h100 | PARB);
        check("tx_before_pop", {31'h0, tx}, 32'h1);
        @(posedge clk);
        #1;
        check("tx_fall", {31'h0, tx}, 32'h0);
        rd(BASE + 32'h4, d, h);
        check("status_after_pop", d, 32'h5 | PARB);
        repeat (FRAME - 1) @(posedge clk);
        #1;
        rd(BASE + 32'h4, d, h);
        check("busy_last_cycle", {31'h0, d[0]}, 32'h1);
        @(posedge clk);
        #1;
        rd(BASE + 32'h4, d, h);
        check("busy_clear", d, EXP_IDLE);
        wait_idle(200);

        // Five consecutive stores, overflow on the sixth, clear via STATUS
        starts.delete();
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        send(8'h5E);
        rd(BASE + 32'h4, d, h);
        check("status_full", d, 32'h403 | PARB);
        wr(BASE, 32'h66);
        rd(BASE + 32'h4, d, h);
        check("status_overflow", d, 32'h40B | PARB);
        wr(BASE + 32'h4, 32'h7);
        rd(BASE + 32'h4, d, h);
        check("ovf_kept_bit3_zero", d, 32'h40B | PARB);
        wr(BASE + 32'h8, 32'h8);
        rd(BASE + 32'h4, d, h);
        check("ovf_kept_reg2_write", d, 32'h40B | PARB);
        wr(BASE + 32'h4, 32'h8);
        rd(BASE + 32'h4, d, h);
        check("ovf_cleared", d, 32'h403 | PARB);
        wait_idle(2000);
        check("burst_frames", 32'(starts.size()), 32'd5);
        for (int i = 1; i < starts.size(); i++)
            check("burst_gap", 32'(starts[i] - starts[i-1]), 32'(FRAME));

        // Two bytes back-to-back
        starts.delete();
        send(8'h3C);
        send(8'hC3);
        wait_idle(1000);
        check("b2b_frames", 32'(starts.size()), 32'd2);
        if (starts.size() == 2)
            check("b2b_gap", 32'(starts[1] - starts[0]), 32'(FRAME));

        send(8'h07);
        wait_idle(500);
        rd(BASE + 32'h4, d, h);
        check("status_after_07", d, EXP_IDLE);

        // Reset mid-DATA with a second byte still queued
        mon_en = 1'b0;
        wr(BASE, 32'h55);
        wr(BASE, 32'h66);
        repeat (CPB + 5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("tx_async_reset", {31'h0, tx}, 32'h1);
        rd(BASE + 32'h4, d, h);
        check("status_in_reset", d, EXP_IDLE);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rd(BASE + 32'h4, d, h);
        check("status_after_reset", d, EXP_IDLE);
        ntx = 0;
        repeat (3 * FRAME) begin
            @(negedge clk);
            if (tx !== 1'b1) ntx++;
        end
        check("tx_quiet_after_reset", 32'(ntx), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the multicycle MIPS core's data bus, downstream of the core's `adr`/`writedata`/`memwrite` outputs. It decodes a 16-byte register window and buffers store bytes in a small FIFO. It serialises them 8N1 on `tx` and returns a status word on a combinational read path, which the system read mux selects over RAM whenever `hit` is high. Reads have no side effects, so instruction fetches and speculative data reads are harmless.

## Interface
Parameters:
- `BASE_ADDR`, 32'hFFFF_FF00: window base; only bits [31:4] are compared.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, 4: TX FIFO entries; must be a power of 2, ≥ 2.

Ports (reset `reset`, asynchronous, active-high; clock `clk`):
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `adr`  in  32  byte address from the core.
- `writedata`  in  32  store data from the core.
- `memwrite`  in  1  store strobe, valid for one cycle.
- `hit`  out  1  combinational; `adr[31:4] == BASE_ADDR[31:4]`.
- `rdata`  out  32  combinational register read data; 0 when `hit` is low.
- `tx`  out  1  registered serial output; idles high.

## Operation
- Register select is `adr[3:2]`; `adr[1:0]` is ignored.
  - 0 TXDATA: a write pushes `writedata[7:0]`; reads return 0.
  - 1 STATUS: reads return bit0 busy, bit1 full, bit2 empty, bit3 overflow, bits[15:8] FIFO count, all other bits 0. A write with `writedata[3]=1` clears overflow.
  - 2 and 3: read 0; writes ignored.
- A write takes effect only when `hit & memwrite` at the clock edge.
- Push to TXDATA:
  - FIFO not full: byte enqueued.
  - FIFO full: byte dropped and overflow set. Full is evaluated before any same-cycle pop, so a pop in the same cycle does not rescue the write.
- Overflow set and clear in the same cycle: set wins.
- Transmit FSM states:
  - IDLE: tx=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: bits 0..7, LSB first, CLKS_PER_BIT cycles each, then go to PARITY (if compiled in) or STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the last cycle: FIFO non-empty → pop and go to START with no idle gap; else go to IDLE.
- busy = (state != IDLE).
- Bit-period counter is `$clog2(CLKS_PER_BIT)` bits; bit index is 3 bits. Both reset to 0 on every state entry.
- Count field is `$clog2(FIFO_DEPTH)+1` bits, zero-extended into bits[15:8]. FIFO pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: tx=1, state IDLE, FIFO empty (count 0), overflow 0, `hit`/`rdata` purely combinational.
- Reset mid-frame: tx returns high immediately and the FIFO is flushed; the in-flight byte is lost.
- Write at edge k into an idle block:
  - FIFO count is 1 after edge k.
  - Pop at edge k+1; tx falls after edge k+1.
  - STATUS read in cycle k+1 shows empty=0, busy=0. From cycle k+2: busy=1, empty=1.
- Frame length: 10×CLKS_PER_BIT cycles, or 11× with parity.
- Back-to-back frames: the start bit immediately follows the stop bit with no idle cycle.
- STATUS reads are combinational; they reflect register state before the current edge.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state after DATA; tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
  - Frame is 11 bit periods.
  - STATUS bit4 reads 1 (parity-capable).
- Undefined: no PARITY state, 10-bit frame, STATUS bit4 reads 0.

## Structure
- Shared package/header `mips_mmio_pkg` holds:
  - Register offsets (TXDATA=0, STATUS=1).
  - STATUS bit positions (BUSY=0, FULL=1, EMPTY=2, OVF=3, PAR=4, COUNT_LSB=8).
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP).
- One sub-module, `uart_txfifo`: synchronous FIFO with push/pop/full/empty/count. It has asynchronous reset and is parameterised by width (8) and depth.

## Test plan
All scenarios use CLKS_PER_BIT=4 and the default BASE_ADDR.
- Reset, then read 0xFFFFFF04: `hit`=1, rdata=32'h0000_0004 (empty only). Read 0x00000004: `hit`=0, rdata=0.
- Write 0xA5 to 0xFFFFFF00: tx falls one cycle after the write edge, then shows bits 1,0,1,0,0,1,0,1 (4 cycles each), then stop high; busy clears 40 cycles after the pop.
- Write 5 bytes on consecutive cycles while idle:
  - All 5 bytes are accepted: the first is popped before the FIFO fills, so overflow=0.
  - Write a 6th byte while count=4: dropped, overflow=1.
  - Write STATUS=0x8: overflow=0.
- Write two bytes back-to-back: tx shows no idle cycle between the first stop bit and the second start bit.
- Assert reset mid-DATA: tx=1 in the same cycle, STATUS returns to 0x4, and no further transitions occur on tx.
- With `UART_TX_PARITY_EN` defined, write 0x07: parity bit = 1 and the frame is 44 cycles; STATUS bit4=1.
